// File: rtl/arp_req_pkg.sv
// Shared types and helpers for the ARP request arbiter.
package arp_req_pkg;

  localparam int unsigned DEF_PORT_W = 4;
  localparam int unsigned DEF_IP_W   = 32;

  // Request record at the default field widths, for producers that use them.
  typedef struct packed {
    logic [DEF_PORT_W-1:0] netport;
    logic [DEF_IP_W-1:0]   ip;
  } arp_req_t;

  // Width of a source index; never narrower than one bit.
  function automatic int unsigned src_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational fixed-priority / round-robin grant selection.
module rr_arbiter
  import arp_req_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned RR_MODE = 1,
  localparam int unsigned SW = src_idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [SW-1:0]      i_ptr,
  input  logic               i_en,
  output logic [NUM_SRC-1:0] o_gnt,
  output logic [SW-1:0]      o_idx,
  output logic               o_any
);

  // Scan candidates in priority order, starting after ptr in round-robin mode.
  always_comb begin
    logic [SW-1:0] cand;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    cand  = '0;
    if (i_en) begin
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        if (RR_MODE != 0) cand = SW'((32'(i_ptr) + 32'd1 + k) % NUM_SRC);
        else              cand = SW'(k);
        if (!o_any && i_req[cand]) begin
          o_any       = 1'b1;
          o_gnt[cand] = 1'b1;
          o_idx       = cand;
        end
      end
    end
  end

endmodule

// File: rtl/arp_req_arb.sv
// ARP request arbiter: per-source holding slots, arbitration, output register
// and duplicate suppression against the last accepted request.
module arp_req_arb
  import arp_req_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned PORT_W  = DEF_PORT_W,
  parameter int unsigned IP_W    = DEF_IP_W,
  parameter int unsigned RR_MODE = 1,
  parameter int unsigned HOLDOFF = 256,
  localparam int unsigned SW = src_idx_w(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        rx_en,
  input  logic [NUM_SRC*PORT_W-1:0] rx_netport,
  input  logic [NUM_SRC*IP_W-1:0]   rx_ip,
  output logic [NUM_SRC-1:0]        rx_busy,
  output logic [NUM_SRC-1:0]        rx_drop,
  output logic                      dup_drop,
  output logic                      tx_req_en,
  input  logic                      tx_req_rdy,
  output logic [PORT_W-1:0]         tx_req_netport,
  output logic [IP_W-1:0]           tx_req_ip,
  output logic [SW-1:0]             tx_req_src
);

  localparam int unsigned HCW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

  logic [NUM_SRC-1:0]     r_full;
  logic [PORT_W-1:0]      r_slot_np [NUM_SRC];
  logic [IP_W-1:0]        r_slot_ip [NUM_SRC];
  logic [SW-1:0]          r_ptr;
  logic [HCW-1:0]         r_hcnt;
  logic [PORT_W+IP_W-1:0] r_last;

  logic                   w_free;
  logic                   w_accept;
  logic [NUM_SRC-1:0]     w_gnt;
  logic [SW-1:0]          w_gidx;
  logic                   w_any;
  logic                   w_dup;
  logic [NUM_SRC-1:0]     w_cap;
  logic [PORT_W-1:0]      w_gnp;
  logic [IP_W-1:0]        w_gip;

  assign w_accept = tx_req_en && tx_req_rdy;
  assign w_free   = !tx_req_en || tx_req_rdy;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .i_req (r_full),
    .i_ptr (r_ptr),
    .i_en  (w_free),
    .o_gnt (w_gnt),
    .o_idx (w_gidx),
    .o_any (w_any)
  );

  // A slot being granted this cycle is free for a same-edge refill.
  assign rx_busy = r_full & ~w_gnt;
  assign w_cap   = rx_en & ~rx_busy;
  assign w_gnp   = r_slot_np[w_gidx];
  assign w_gip   = r_slot_ip[w_gidx];
  assign w_dup   = (HOLDOFF != 0) && (r_hcnt != '0) && ({w_gnp, w_gip} == r_last);

  // Slot capture and release; capture wins over release on a refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        r_slot_np[i] <= '0;
        r_slot_ip[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (w_cap[i]) begin
          r_full[i]    <= 1'b1;
          r_slot_np[i] <= rx_netport[i*PORT_W +: PORT_W];
          r_slot_ip[i] <= rx_ip[i*IP_W +: IP_W];
        end else if (w_gnt[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  // Output register: load on a non-duplicate grant, clear to zero when drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_req_en      <= 1'b0;
      tx_req_netport <= '0;
      tx_req_ip      <= '0;
      tx_req_src     <= '0;
    end else if (w_any && !w_dup) begin
      tx_req_en      <= 1'b1;
      tx_req_netport <= w_gnp;
      tx_req_ip      <= w_gip;
      tx_req_src     <= w_gidx;
    end else if (w_accept) begin
      tx_req_en      <= 1'b0;
      tx_req_netport <= '0;
      tx_req_ip      <= '0;
      tx_req_src     <= '0;
    end
  end

  // Round-robin pointer, hold-off window and last accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= SW'(NUM_SRC - 1);
      r_hcnt <= '0;
      r_last <= '0;
    end else begin
      if (RR_MODE != 0 && w_any) r_ptr <= w_gidx;
      if (w_accept) begin
        r_last <= {tx_req_netport, tx_req_ip};
        r_hcnt <= HCW'(HOLDOFF);
      end else if (r_hcnt != '0) begin
        r_hcnt <= r_hcnt - HCW'(1);
      end
    end
  end

  // Registered loss indications.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_drop  <= '0;
      dup_drop <= 1'b0;
    end else begin
      rx_drop  <= rx_en & rx_busy;
      dup_drop <= w_any && w_dup;
    end
  end

endmodule

// File: tb/tb_arp_req_arb.sv
// Directed bench: fixed-priority instance (2 sources, hold-off 16) and
// round-robin instance (4 sources, hold-off disabled).
module tb_arp_req_arb;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // Fixed-priority instance
  logic [1:0]  a_rx_en;
  logic [7:0]  a_np;
  logic [63:0] a_ip;
  logic [1:0]  a_busy, a_drop;
  logic        a_dup, a_en, a_rdy;
  logic [3:0]  a_onp;
  logic [31:0] a_oip;
  logic [0:0]  a_osrc;

  // Round-robin instance
  logic [3:0]   b_rx_en;
  logic [15:0]  b_np;
  logic [127:0] b_ip;
  logic [3:0]   b_busy, b_drop;
  logic         b_dup, b_en, b_rdy;
  logic [3:0]   b_onp;
  logic [31:0]  b_oip;
  logic [1:0]   b_osrc;

  logic [37:0] a_tup;
  logic [38:0] b_tup;
  assign a_tup = {a_en, a_osrc, a_onp, a_oip};
  assign b_tup = {b_en, b_osrc, b_onp, b_oip};

  arp_req_arb #(
    .NUM_SRC (2), .PORT_W (4), .IP_W (32), .RR_MODE (0), .HOLDOFF (16)
  ) u_fix (
    .clk (clk), .rst_n (rst_n),
    .rx_en (a_rx_en), .rx_netport (a_np), .rx_ip (a_ip),
    .rx_busy (a_busy), .rx_drop (a_drop), .dup_drop (a_dup),
    .tx_req_en (a_en), .tx_req_rdy (a_rdy),
    .tx_req_netport (a_onp), .tx_req_ip (a_oip), .tx_req_src (a_osrc)
  );

  arp_req_arb #(
    .NUM_SRC (4), .PORT_W (4), .IP_W (32), .RR_MODE (1), .HOLDOFF (0)
  ) u_rr (
    .clk (clk), .rst_n (rst_n),
    .rx_en (b_rx_en), .rx_netport (b_np), .rx_ip (b_ip),
    .rx_busy (b_busy), .rx_drop (b_drop), .dup_drop (b_dup),
    .tx_req_en (b_en), .tx_req_rdy (b_rdy),
    .tx_req_netport (b_onp), .tx_req_ip (b_oip), .tx_req_src (b_osrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_rx_en = '0; a_np = '0; a_ip = '0; a_rdy = 1'b0;
    b_rx_en = '0; b_np = '0; b_ip = '0; b_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (a_tup !== 38'h0) begin bad++; $display("FAIL reset_a_out got=%h exp=0", a_tup); end
    total++; if ({a_busy, a_drop, a_dup} !== 5'b0) begin bad++; $display("FAIL reset_a_flags got=%b exp=0", {a_busy, a_drop, a_dup}); end
    total++; if (b_tup !== 39'h0) begin bad++; $display("FAIL reset_b_out got=%h exp=0", b_tup); end
    total++; if ({b_busy, b_drop, b_dup} !== 9'b0) begin bad++; $display("FAIL reset_b_flags got=%b exp=0", {b_busy, b_drop, b_dup}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fixed();
    a_rdy = 1'b1;
    a_np = {4'd2, 4'd1};
    a_ip = {32'h0A000002, 32'h0A000001};
    a_rx_en = 2'b11;
    tick();
    a_rx_en = 2'b00;
    total++; if (a_en !== 1'b0) begin bad++; $display("FAIL fix_latency got=%b exp=0", a_en); end
    total++; if (a_busy !== 2'b10) begin bad++; $display("FAIL fix_busy got=%b exp=10", a_busy); end
    tick();
    total++; if (a_tup !== {1'b1, 1'b0, 4'd1, 32'h0A000001}) begin bad++; $display("FAIL fix_first got=%h exp=%h", a_tup, {1'b1, 1'b0, 4'd1, 32'h0A000001}); end
    tick();
    total++; if (a_tup !== {1'b1, 1'b1, 4'd2, 32'h0A000002}) begin bad++; $display("FAIL fix_second got=%h exp=%h", a_tup, {1'b1, 1'b1, 4'd2, 32'h0A000002}); end
    tick();
    total++; if (a_tup !== 38'h0) begin bad++; $display("FAIL fix_idle got=%h exp=0", a_tup); end
  endtask

  task automatic test_busy_drop();
    a_rdy = 1'b0;
    a_np[7:4] = 4'd6; a_ip[63:32] = 32'h0A000006;
    a_rx_en = 2'b10;
    tick();
    a_rx_en = 2'b00;
    tick();
    total++; if (a_tup !== {1'b1, 1'b1, 4'd6, 32'h0A000006}) begin bad++; $display("FAIL drop_hold got=%h exp=%h", a_tup, {1'b1, 1'b1, 4'd6, 32'h0A000006}); end
    a_np[3:0] = 4'd5; a_ip[31:0] = 32'h0A000005;
    a_rx_en = 2'b01;
    tick();
    a_rx_en = 2'b00;
    tick();
    tick();
    total++; if (a_busy !== 2'b01) begin bad++; $display("FAIL drop_busy got=%b exp=01", a_busy); end
    a_np[3:0] = 4'd7; a_ip[31:0] = 32'h0A000007;
    a_rx_en = 2'b01;
    tick();
    a_rx_en = 2'b00;
    total++; if (a_drop !== 2'b01) begin bad++; $display("FAIL drop_pulse got=%b exp=01", a_drop); end
    total++; if (a_tup !== {1'b1, 1'b1, 4'd6, 32'h0A000006}) begin bad++; $display("FAIL drop_stall got=%h exp=%h", a_tup, {1'b1, 1'b1, 4'd6, 32'h0A000006}); end
    tick();
    total++; if (a_drop !== 2'b00) begin bad++; $display("FAIL drop_once got=%b exp=00", a_drop); end
    a_rdy = 1'b1;
    tick();
    total++; if (a_tup !== {1'b1, 1'b0, 4'd5, 32'h0A000005}) begin bad++; $display("FAIL drop_first_kept got=%h exp=%h", a_tup, {1'b1, 1'b0, 4'd5, 32'h0A000005}); end
    tick();
    total++; if (a_tup !== 38'h0) begin bad++; $display("FAIL drop_second_lost got=%h exp=0", a_tup); end
  endtask

  task automatic test_dup();
    a_rdy = 1'b1;
    a_np[3:0] = 4'd3; a_ip[31:0] = 32'hC0A80101;
    a_rx_en = 2'b01;
    tick();
    a_rx_en = 2'b00;
    tick();
    total++; if (a_tup !== {1'b1, 1'b0, 4'd3, 32'hC0A80101}) begin bad++; $display("FAIL dup_orig got=%h exp=%h", a_tup, {1'b1, 1'b0, 4'd3, 32'hC0A80101}); end
    tick();
    repeat (3) tick();
    a_rx_en = 2'b01;
    tick();
    a_rx_en = 2'b00;
    tick();
    total++; if (a_dup !== 1'b1) begin bad++; $display("FAIL dup_pulse got=%b exp=1", a_dup); end
    total++; if (a_tup !== 38'h0) begin bad++; $display("FAIL dup_no_out got=%h exp=0", a_tup); end
    tick();
    total++; if ({a_dup, a_tup} !== 39'h0) begin bad++; $display("FAIL dup_after got=%h exp=0", {a_dup, a_tup}); end
    repeat (20) tick();
    a_rx_en = 2'b01;
    tick();
    a_rx_en = 2'b00;
    tick();
    total++; if ({a_dup, a_tup} !== {1'b0, 1'b1, 1'b0, 4'd3, 32'hC0A80101}) begin bad++; $display("FAIL dup_window_over got=%h exp=%h", {a_dup, a_tup}, {1'b0, 1'b1, 1'b0, 4'd3, 32'hC0A80101}); end
    tick();
  endtask

  task automatic test_refill();
    a_rdy = 1'b1;
    a_np[7:4] = 4'd8; a_ip[63:32] = 32'h0A000008;
    a_rx_en = 2'b10;
    tick();
    a_np[7:4] = 4'd9; a_ip[63:32] = 32'h0A000009;
    #1;
    total++; if (a_busy !== 2'b00) begin bad++; $display("FAIL refill_busy got=%b exp=00", a_busy); end
    tick();
    a_rx_en = 2'b00;
    total++; if ({a_drop, a_tup} !== {2'b00, 1'b1, 1'b1, 4'd8, 32'h0A000008}) begin bad++; $display("FAIL refill_first got=%h exp=%h", {a_drop, a_tup}, {2'b00, 1'b1, 1'b1, 4'd8, 32'h0A000008}); end
    tick();
    total++; if ({a_drop, a_tup} !== {2'b00, 1'b1, 1'b1, 4'd9, 32'h0A000009}) begin bad++; $display("FAIL refill_second got=%h exp=%h", {a_drop, a_tup}, {2'b00, 1'b1, 1'b1, 4'd9, 32'h0A000009}); end
    tick();
    total++; if (a_tup !== 38'h0) begin bad++; $display("FAIL refill_idle got=%h exp=0", a_tup); end
  endtask

  task automatic test_rr();
    logic [38:0] exp;
    b_rdy = 1'b0;
    b_np = {4'd4, 4'd3, 4'd2, 4'd1};
    b_ip = {32'h000000B3, 32'h000000B2, 32'h000000B1, 32'h000000B0};
    b_rx_en = 4'hF;
    tick();
    b_rx_en = 4'h0;
    tick();
    for (int s = 0; s < 5; s++) begin
      if (s < 4) exp = {1'b1, 2'(s), 4'(s + 1), 32'h000000B0 + 32'(s)};
      else       exp = {1'b1, 2'd0, 4'd5, 32'h000000C0};
      total++; if (b_tup !== exp) begin bad++; $display("FAIL rr_step%0d got=%h exp=%h", s, b_tup, exp); end
      tick();
      total++; if (b_tup !== exp) begin bad++; $display("FAIL rr_stall%0d got=%h exp=%h", s, b_tup, exp); end
      b_rdy = 1'b1;
      if (s < 4) begin
        b_np[s*4 +: 4]  = 4'(s + 5);
        b_ip[s*32 +: 32] = 32'h000000C0 + 32'(s);
        b_rx_en = 4'(1 << s);
      end
      tick();
      b_rx_en = 4'h0;
      b_rdy = 1'b0;
    end
    b_rdy = 1'b1;
    repeat (4) tick();
    total++; if ({b_busy, b_tup} !== 43'h0) begin bad++; $display("FAIL rr_drain got=%h exp=0", {b_busy, b_tup}); end
  endtask

  task automatic test_holdoff_off();
    b_rdy = 1'b1;
    b_np[3:0] = 4'd1; b_ip[31:0] = 32'h000000B0;
    b_rx_en = 4'b0001;
    tick();
    b_rx_en = 4'h0;
    tick();
    tick();
    b_rx_en = 4'b0001;
    tick();
    b_rx_en = 4'h0;
    tick();
    total++; if ({b_dup, b_tup} !== {1'b0, 1'b1, 2'd0, 4'd1, 32'h000000B0}) begin bad++; $display("FAIL nohold_repeat got=%h exp=%h", {b_dup, b_tup}, {1'b0, 1'b1, 2'd0, 4'd1, 32'h000000B0}); end
    tick();
  endtask

  task automatic test_async_reset();
    a_rdy = 1'b0; b_rdy = 1'b0;
    a_np = {4'd11, 4'd10}; a_ip = {32'h0A00000B, 32'h0A00000A};
    a_rx_en = 2'b11; b_rx_en = 4'hF;
    tick();
    a_rx_en = 2'b00; b_rx_en = 4'h0;
    tick();
    total++; if (a_tup !== {1'b1, 1'b0, 4'd10, 32'h0A00000A}) begin bad++; $display("FAIL ares_pre got=%h exp=%h", a_tup, {1'b1, 1'b0, 4'd10, 32'h0A00000A}); end
    #3 rst_n = 1'b0;
    #1;
    total++; if ({a_busy, a_drop, a_dup, a_tup} !== 43'h0) begin bad++; $display("FAIL ares_a got=%h exp=0", {a_busy, a_drop, a_dup, a_tup}); end
    total++; if ({b_busy, b_drop, b_dup, b_tup} !== 48'h0) begin bad++; $display("FAIL ares_b got=%h exp=0", {b_busy, b_drop, b_dup, b_tup}); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    a_rdy = 1'b1; b_rdy = 1'b1;
    a_np = {4'd13, 4'd12}; a_ip = {32'h0A00000D, 32'h0A00000C};
    b_np = {4'd4, 4'd0, 4'd0, 4'd1};
    b_ip = {32'h000000D3, 32'h0, 32'h0, 32'h000000D0};
    a_rx_en = 2'b11; b_rx_en = 4'b1001;
    tick();
    a_rx_en = 2'b00; b_rx_en = 4'h0;
    tick();
    total++; if (a_tup !== {1'b1, 1'b0, 4'd12, 32'h0A00000C}) begin bad++; $display("FAIL ares_a_first got=%h exp=%h", a_tup, {1'b1, 1'b0, 4'd12, 32'h0A00000C}); end
    total++; if (b_tup !== {1'b1, 2'd0, 4'd1, 32'h000000D0}) begin bad++; $display("FAIL ares_b_first got=%h exp=%h", b_tup, {1'b1, 2'd0, 4'd1, 32'h000000D0}); end
    tick();
    total++; if (a_tup !== {1'b1, 1'b1, 4'd13, 32'h0A00000D}) begin bad++; $display("FAIL ares_a_second got=%h exp=%h", a_tup, {1'b1, 1'b1, 4'd13, 32'h0A00000D}); end
    total++; if (b_tup !== {1'b1, 2'd3, 4'd4, 32'h000000D3}) begin bad++; $display("FAIL ares_b_second got=%h exp=%h", b_tup, {1'b1, 2'd3, 4'd4, 32'h000000D3}); end
    tick();
    total++; if ({a_tup, b_tup} !== 77'h0) begin bad++; $display("FAIL ares_idle got=%h exp=0", {a_tup, b_tup}); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fixed();
    test_busy_drop();
    test_dup();
    test_refill();
    test_rr();
    test_holdoff_off();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arp_req_arb.md
# arp_req_arb

Parametrised ARP request arbiter that collects request strobes ({netport, ip}) from NUM_SRC producers (table-miss lookup, entry-fade refresh, host-triggered probes, etc.) and presents them one at a time to the ARP request transmitter over a valid/ready handshake. Each source has a one-entry holding slot, so a strobe arriving while the transmitter is busy is not lost. Arbitration is fixed-priority or round-robin. Back-to-back duplicate requests for the same {netport, ip} are suppressed within a programmable hold-off window.

## Interface
Parameters:
- NUM_SRC, 2: number of request sources, 2..8. Index 0 is highest priority in fixed mode.
- PORT_W, 4: netport width.
- IP_W, 32: IPv4 address width.
- RR_MODE, 1: 1 selects round-robin arbitration; 0 selects fixed priority, lowest index wins.
- HOLDOFF, 256: duplicate-suppression window in clk cycles; 0 disables suppression.

Ports:
- clk  in  1  sole clock; all logic is rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_en  in  NUM_SRC  per-source single-cycle request strobe.
- rx_netport  in  NUM_SRC*PORT_W  packed netports; source i occupies bits [i*PORT_W +: PORT_W].
- rx_ip  in  NUM_SRC*IP_W  packed IPs; same packing rule.
- rx_busy  out  NUM_SRC  slot i is full and not being freed this cycle (combinational).
- rx_drop  out  NUM_SRC  registered 1-cycle pulse: strobe on source i was lost because its slot was busy.
- dup_drop  out  1  registered 1-cycle pulse: a granted request was discarded as a duplicate.
- tx_req_en  out  1  output valid.
- tx_req_rdy  in  1  transmitter accepts when tx_req_en && tx_req_rdy.
- tx_req_netport  out  PORT_W  request netport.
- tx_req_ip  out  IP_W  request IP.
- tx_req_src  out  max(1,$clog2(NUM_SRC))  index of the source that produced the output.

## Operation
- **Slot capture.** On rx_en[i] with rx_busy[i]=0, slot i loads {netport, ip} and sets full.
- **Busy strobe.** On rx_en[i] with rx_busy[i]=1, the strobe is discarded and rx_drop[i] pulses on the next cycle.
- **Grant condition.** The output register is free when tx_req_en=0 or when the current output is accepted this cycle. When it is free, the arbiter grants one full slot.
  - RR_MODE=1: search starts at ptr+1 modulo NUM_SRC; ptr becomes the granted index.
  - RR_MODE=0: the lowest full index wins; ptr is unused.
- **Granted slot.** The granted slot clears, and {netport, ip, index} load the output register with tx_req_en=1.
- **Duplicate suppression.** If HOLDOFF≠0, holdoff_cnt≠0, and the granted {netport, ip} equals last_issued:
  - the slot clears and ptr advances;
  - the output register is not loaded (tx_req_en stays low unless it was already holding an item);
  - dup_drop pulses.
- **Accept.** On accept (tx_req_en && tx_req_rdy), last_issued takes the output {netport, ip} and holdoff_cnt reloads to HOLDOFF. Otherwise holdoff_cnt decrements, saturating at 0.
- **Output hold.** Output fields are held stable while tx_req_en=1 and tx_req_rdy=0.
- **Idle output.** With no grant and no held item, tx_req_en=0 and tx_req_netport, tx_req_ip and tx_req_src are 0.
- **Reset (async).**
  - Outputs: tx_req_en, tx_req_netport, tx_req_ip, tx_req_src, rx_drop and dup_drop are 0. rx_busy is 0 because all slots are empty.
  - Internal state: ptr=NUM_SRC-1 (so index 0 is searched first), holdoff_cnt=0, last_issued=0.
  - Assertion mid-transfer drops all slot contents and the held output; no partial state survives.

## Timing
- **Latency.** rx_en sampled at edge N gives a full slot after N. With the output free, the item is granted and registered at edge N+1, so tx_req_en is high after N+1. Minimum latency is 2 cycles.
- **Throughput.** One item per cycle with tx_req_rdy held high (accept and reload on the same edge).
- **Same-slot refill.** If slot i is granted at edge N and rx_en[i] is high in the same cycle, rx_busy[i]=0 and the new request is captured at N. The slot stays full with new content, so no drop occurs.
- **Simultaneous strobes.** All sources are captured in the same cycle and drained in arbitration order, one per free output cycle.
- **Duplicate timing.** A duplicate consumes one grant cycle.
- **Hold-off boundary.** A request equal to last_issued is passed when it is granted on or after the HOLDOFF-th cycle after the accept edge, i.e. once holdoff_cnt has reached 0.
- **Round-robin wrap.** ptr wraps from NUM_SRC-1 to 0.

## Structure
- **Shared package arp_req_pkg:**
  - default PORT_W/IP_W constants;
  - the arp_req_t struct {netport, ip};
  - the helper function computing the src index width.
- **Sub-module rr_arbiter:**
  - parameters NUM_SRC and RR_MODE;
  - inputs: request vector, ptr, grant-enable;
  - outputs: one-hot grant, encoded index, any_grant;
  - purely combinational; ptr stays in arp_req_arb.
- **arp_req_arb:** slots, output register, hold-off counter and last_issued compare.

## Test plan
- **Fixed priority, idle output.** NUM_SRC=2, RR_MODE=0, tx_req_rdy=1. Same-cycle strobes src0 {1, 0x0A000001} and src1 {2, 0x0A000002} → two outputs on consecutive cycles, src0 first; tx_req_en is first high 2 cycles after the strobe.
- **Round-robin, stalled transmitter.** NUM_SRC=4, RR_MODE=1. Keep all slots refilled while tx_req_rdy toggles → tx_req_src sequence 0,1,2,3,0; the output is stable during every stall cycle.
- **Busy drop.** tx_req_rdy=0, then src0 strobes twice 3 cycles apart → the second strobe is lost, rx_drop[0] pulses once, and only the first request appears when rdy rises.
- **Duplicate suppression.** HOLDOFF=16. Accept {3, 0xC0A80101}, then re-request it after 5 cycles → dup_drop pulses with no output. Re-request after ≥16 cycles → it is output.
- **Same-edge refill.** Strobe src1 on the edge where slot 1 is granted → no rx_drop, and the second request appears after the first.
- **Async reset mid-stall.** Assert rst_n low with tx_req_en=1 and slots full → all outputs are 0 immediately. After release, the first strobe is granted from src0 search order.
